scan_addr_gen: RTL and testbench

SCAN_ADDR_GEN -- requirements
Module: scan_addr_gen

---
 rtl/scan_pkg.sv | 13 +
 rtl/scan_axis_counter.sv | 34 +++
 rtl/scan_addr_gen.sv | 138 +++++++++++++
 tb/tb_scan_addr_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and default widths for the scan address generator.
package scan_pkg;

  localparam int CW_DEF = 16;
  localparam int AW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/scan_axis_counter.sv
// One scan axis: wrapping up/down counter with a configurable reload value on wrap.
module scan_axis_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic          dir,
  input  logic          reload_dir,
  input  logic [CW-1:0] max,
  output logic [CW-1:0] cnt,
  output logic          at_end,
  output logic          wrap
);

  // dir=1 counts down, so its end of travel is 0 rather than max
  assign at_end = dir ? (cnt == '0) : (cnt == max);
  assign wrap   = step & at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      if (at_end)
        cnt <= reload_dir ? max : '0;
      else
        cnt <= dir ? cnt - CW'(1) : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/scan_addr_gen.sv
// 3-D raster scan address generator with valid/ready beats.
// Define SCAN_SERPENTINE_EN to reverse x on odd global rows.
module scan_addr_gen
  import scan_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] w_max,
  input  logic [CW-1:0] h_max,
  input  logic [CW-1:0] d_max,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] row_pitch,
  input  logic [AW-1:0] plane_pitch,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [CW-1:0] z,
  output logic [AW-1:0] addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          last,
  output logic          busy,
  output logic          done
);

`ifdef SCAN_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  state_t        state;
  logic [CW-1:0] w_r, h_r, d_r;
  logic [AW-1:0] rp_r, pp_r, row_base, plane_base;
  logic          row_odd;
  logic          x_end, y_end, z_end, x_wrap, y_wrap, z_wrap;
  logic          adv, load, x_dir, x_rdir;
  logic [AW-1:0] x_reload;

  assign load     = (state == IDLE) & start & ~abort;
  assign adv      = (state == RUN) & out_valid & out_ready & ~abort;
  assign x_dir    = SERP & row_odd;
  assign x_rdir   = SERP & ~row_odd;
  assign x_reload = x_rdir ? AW'(w_r) : '0;
  assign last     = out_valid & x_end & y_end & z_end;

  scan_axis_counter #(.CW(CW)) u_x (
    .clk(clk), .rst(rst), .load(load), .step(adv), .dir(x_dir),
    .reload_dir(x_rdir), .max(w_r), .cnt(x), .at_end(x_end), .wrap(x_wrap)
  );

  scan_axis_counter #(.CW(CW)) u_y (
    .clk(clk), .rst(rst), .load(load), .step(x_wrap), .dir(1'b0),
    .reload_dir(1'b0), .max(h_r), .cnt(y), .at_end(y_end), .wrap(y_wrap)
  );

  scan_axis_counter #(.CW(CW)) u_z (
    .clk(clk), .rst(rst), .load(load), .step(y_wrap), .dir(1'b0),
    .reload_dir(1'b0), .max(d_r), .cnt(z), .at_end(z_end), .wrap(z_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr       <= '0;
      row_base   <= '0;
      plane_base <= '0;
      row_odd    <= 1'b0;
      w_r        <= '0;
      h_r        <= '0;
      d_r        <= '0;
      rp_r       <= '0;
      pp_r       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            w_r        <= w_max;
            h_r        <= h_max;
            d_r        <= d_max;
            rp_r       <= row_pitch;
            pp_r       <= plane_pitch;
            addr       <= base_addr;
            row_base   <= base_addr;
            plane_base <= base_addr;
            row_odd    <= 1'b0;
            out_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (adv) begin
            // z_wrap is the accepted final beat; otherwise step the address incrementally
            if (z_wrap) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else if (!x_end) begin
              addr <= x_dir ? addr - AW'(1) : addr + AW'(1);
            end else if (!y_end) begin
              row_base <= row_base + rp_r;
              addr     <= row_base + rp_r + x_reload;
              row_odd  <= ~row_odd;
            end else begin
              plane_base <= plane_base + pp_r;
              row_base   <= plane_base + pp_r;
              addr       <= plane_base + pp_r + x_reload;
              row_odd    <= ~row_odd;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed self-checking bench for scan_addr_gen.
module tb_scan_addr_gen;

  localparam int CW = 16;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] w_max = '0, h_max = '0, d_max = '0;
  logic [AW-1:0] base_addr = '0, row_pitch = '0, plane_pitch = '0;
  logic [CW-1:0] x, y, z;
  logic [AW-1:0] addr;
  logic          out_valid, last, busy, done;

  int n_err = 0;
  int n_chk = 0;

  scan_addr_gen #(.CW(CW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .w_max(w_max), .h_max(h_max), .d_max(d_max),
    .base_addr(base_addr), .row_pitch(row_pitch), .plane_pitch(plane_pitch),
    .x(x), .y(y), .z(z), .addr(addr),
    .out_valid(out_valid), .out_ready(out_ready), .last(last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_z"}, z, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] t1_addr [6];
    logic [AW-1:0] serp_addr [6];
    logic [CW-1:0] serp_x [6];
    int b, stall, fin, ex, ey, ez;

    t1_addr   = '{32'h100, 32'h101, 32'h102, 32'h110, 32'h111, 32'h112};
    serp_addr = '{32'h100, 32'h101, 32'h102, 32'h112, 32'h111, 32'h110};
    serp_x    = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd1, 16'd0};

    // reset state
    tick(); tick(); tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();
    chk("idle_valid", out_valid, 0);

    // 3x2x1 raster, config changed mid-run must be ignored
    w_max = 2; h_max = 1; d_max = 0;
    base_addr = 32'h100; row_pitch = 32'h10; plane_pitch = 32'h1000;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    w_max = 7; base_addr = 32'hF00; row_pitch = 32'h40;
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_valid%0d", i), out_valid, 1);
      chk($sformatf("t1_addr%0d", i), addr, t1_addr[i]);
      chk($sformatf("t1_last%0d", i), last, (i == 5));
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_done_valid", out_valid, 0);
    chk("t1_done_busy", busy, 1);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_busy", busy, 0);

    // backpressure: ready low for 3 cycles while beat 3 is presented
    w_max = 2; h_max = 1; d_max = 1;
    base_addr = 32'h100; row_pitch = 32'h10; plane_pitch = 32'h1000;
    start = 1'b1; tick(); start = 1'b0;
    b = 0; stall = 0; fin = 0;
    for (int c = 0; c < 40 && fin == 0; c++) begin
      out_ready = !(b == 2 && stall < 3);
      ex = b % 3; ey = (b / 3) % 2; ez = b / 6;
      chk($sformatf("t2_valid_b%0d", b), out_valid, 1);
      chk($sformatf("t2_x_b%0d", b), x, ex);
      chk($sformatf("t2_y_b%0d", b), y, ey);
      chk($sformatf("t2_z_b%0d", b), z, ez);
      chk($sformatf("t2_addr_b%0d", b), addr, 32'h100 + ez * 32'h1000 + ey * 32'h10 + ex);
      chk($sformatf("t2_last_b%0d", b), last, (b == 11));
      if (!out_ready) stall++;
      else begin
        if (b == 11) fin = 1;
        b++;
      end
      tick();
    end
    out_ready = 1'b1;
    chk("t2_beats", b, 12);
    chk("t2_done", done, 1);
    tick();

    // degenerate single-beat scan
    w_max = 0; h_max = 0; d_max = 0; base_addr = 32'h55;
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_valid", out_valid, 1);
    chk("t3_xyz", {x, y, z}, 0);
    chk("t3_addr", addr, 32'h55);
    chk("t3_last", last, 1);
    tick();
    chk("t3_done", done, 1);
    chk("t3_valid_off", out_valid, 0);
    tick();
    chk("t3_done_pulse", done, 0);
    chk("t3_busy", busy, 0);

    // abort at beat 4 of 8, then restart
    w_max = 1; h_max = 1; d_max = 1;
    base_addr = 32'h2000; row_pitch = 32'h20; plane_pitch = 32'h400;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t4_x", x, 1);
    chk("t4_y", y, 1);
    chk("t4_addr", addr, 32'h2021);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    tick();
    chk("t4_done2", done, 0);
    chk("t4_valid2", out_valid, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_rs_valid", out_valid, 1);
    chk("t4_rs_xyz", {x, y, z}, 0);
    chk("t4_rs_addr", addr, 32'h2000);

    // start during RUN ignored, then reset mid-scan
    tick();
    chk("t5_x", x, 1);
    chk("t5_addr", addr, 32'h2001);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_ign_x", x, 0);
    chk("t5_ign_y", y, 1);
    chk("t5_ign_addr", addr, 32'h2020);
    rst = 1'b1; tick();
    chk_reset_vals("t5_rst");
    rst = 1'b0; tick();
    chk("t5_post_valid", out_valid, 0);
    chk("t5_post_done", done, 0);
    chk("t5_post_busy", busy, 0);

`ifdef SCAN_SERPENTINE_EN
    w_max = 2; h_max = 1; d_max = 0;
    base_addr = 32'h100; row_pitch = 32'h10; plane_pitch = 32'h1000;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("sp_x%0d", i), x, serp_x[i]);
      chk($sformatf("sp_addr%0d", i), addr, serp_addr[i]);
      chk($sformatf("sp_last%0d", i), last, (i == 5));
      tick();
    end
    chk("sp_done", done, 1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
